// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Holds the FSM encoding and the frame-format constants.
package uart_pkg;

  localparam int   DATA_BITS  = 8;
  localparam logic STOP_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Input synchroniser for the asynchronous rx line.
// Flops reset to the idle (high) level so reset never looks like a start bit.
module uart_rx_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d_i};
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames, centre sampling, valid/ready holding register.
// Define UART_RX_PARITY_EN for an even-parity bit and a parity_err_o output.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 frame_err_o,
  output logic                 overrun_o,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err_o,
`endif
  output logic                 busy_o
);

  localparam int CW = $clog2(CLK_PER_BIT) + 1;
  localparam logic [CW-1:0] HALF_M1  = CW'(CLK_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_END  = CW'(CLK_PER_BIT - 1);
  localparam logic [2:0]    BIT_LAST = 3'(DATA_BITS - 1);

  logic rx_s;

  uart_rx_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .d_i    (rx_i),
    .q_o    (rx_s)
  );

  state_e               state_q, state_d;
  logic [CW-1:0]        clk_cnt_q, clk_cnt_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 par_bad;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad_q, par_bad_d;
  logic                 parity_err_q, parity_err_d;
  assign par_bad = par_bad_q;
`else
  assign par_bad = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q + CW'(1);
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q && !ready_i;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        clk_cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (clk_cnt_q == HALF_M1) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (clk_cnt_q == BIT_END) begin
          clk_cnt_d          = '0;
          shift_d[bit_cnt_q] = rx_s;
          bit_cnt_d          = bit_cnt_q + 3'd1;
          if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (clk_cnt_q == BIT_END) begin
          clk_cnt_d = '0;
          par_bad_d = (^shift_q) ^ rx_s;
          state_d   = STOP;
        end
      end
`endif
      STOP: begin
        if (clk_cnt_q == BIT_END) begin
          clk_cnt_d = '0;
          if (rx_s == STOP_LEVEL) begin
            state_d = IDLE;
            if (par_bad) begin
`ifdef UART_RX_PARITY_EN
              parity_err_d = 1'b1;
`endif
            end else if (!valid_q || ready_i) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            // framing error wins over parity: only frame_err pulses
            frame_err_d = 1'b1;
            state_d     = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        clk_cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: begin
        clk_cnt_d = '0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      clk_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign rx_data_o   = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;
  assign busy_o      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err_o = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: CLK_PER_BIT=4 main instance, 16 for glitch.
// Build with UART_RX_PARITY_EN to add the parity scenario.
module tb_uart_rx;

  localparam int CPB = 4;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic       rx_i = 1'b1;
  logic       ready_i = 1'b1;
  logic [7:0] rx_data_o;
  logic       valid_o, frame_err_o, overrun_o, busy_o;

  logic       rx16 = 1'b1;
  logic [7:0] data16;
  logic       valid16, fe16, ov16, busy16;
`ifdef UART_RX_PARITY_EN
  logic       pe, pe16;
`endif

  int tests_run = 0;
  int tests_failed = 0;
  int n_xfer = 0;
  int n_fe = 0;
  int n_ov = 0;
  int n_pe = 0;
  logic [7:0] xq[$];

  uart_rx #(.CLK_PER_BIT(CPB), .SYNC_STAGES(2)) u_dut (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .rx_i       (rx_i),
    .rx_data_o  (rx_data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .frame_err_o(frame_err_o),
    .overrun_o  (overrun_o),
`ifdef UART_RX_PARITY_EN
    .parity_err_o(pe),
`endif
    .busy_o     (busy_o)
  );

  uart_rx #(.CLK_PER_BIT(16), .SYNC_STAGES(2)) u_dut16 (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .rx_i       (rx16),
    .rx_data_o  (data16),
    .valid_o    (valid16),
    .ready_i    (1'b1),
    .frame_err_o(fe16),
    .overrun_o  (ov16),
`ifdef UART_RX_PARITY_EN
    .parity_err_o(pe16),
`endif
    .busy_o     (busy16)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid_o && ready_i) begin
      n_xfer++;
      xq.push_back(rx_data_o);
    end
    if (frame_err_o) n_fe++;
    if (overrun_o) n_ov++;
`ifdef UART_RX_PARITY_EN
    if (pe) n_pe++;
`endif
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic even_par(input logic [7:0] d);
    return ^d;
  endfunction

  task automatic send_frame(input logic [7:0] d, input logic par,
                            input logic stop, input int nbits);
    logic [10:0] f;
`ifdef UART_RX_PARITY_EN
    f = {stop, par, d, 1'b0};
`else
    f = {1'b0, stop, d, 1'b0};
    if (par) f[10] = 1'b0;
`endif
    for (int i = 0; i < nbits; i++) begin
      rx_i = f[i];
      tick(CPB);
    end
  endtask

  task automatic test_reset;
    reset_i = 1'b1;
    rx_i = 1'b1;
    ready_i = 1'b1;
    tick(3);
    tests_run++;
    if (rx_data_o !== 8'h00) begin tests_failed++; $display("FAIL rst_data: got %h want 00", rx_data_o); end
    tests_run++;
    if ({valid_o, frame_err_o, overrun_o, busy_o} !== 4'b0000) begin
      tests_failed++; $display("FAIL rst_flags: got %b want 0000", {valid_o, frame_err_o, overrun_o, busy_o});
    end
    tests_run++;
    if ({valid16, busy16} !== 2'b00) begin tests_failed++; $display("FAIL rst_dut16: got %b want 00", {valid16, busy16}); end
    reset_i = 1'b0;
    tick(2);
  endtask

  task automatic test_basic;
    int x0;
    x0 = n_xfer;
    ready_i = 1'b1;
    send_frame(8'hA5, even_par(8'hA5), 1'b1, NB);
    tests_run++;
    if (valid_o !== 1'b0) begin tests_failed++; $display("FAIL basic_early: got %b want 0", valid_o); end
    tick(1);
    tests_run++;
    if (valid_o !== 1'b1) begin tests_failed++; $display("FAIL basic_valid: got %b want 1", valid_o); end
    tests_run++;
    if (rx_data_o !== 8'hA5) begin tests_failed++; $display("FAIL basic_data: got %h want a5", rx_data_o); end
    tick(1);
    tests_run++;
    if (valid_o !== 1'b0) begin tests_failed++; $display("FAIL basic_drop: got %b want 0", valid_o); end
    tick(4);
    tests_run++;
    if (n_xfer - x0 !== 1) begin tests_failed++; $display("FAIL basic_count: got %0d want 1", n_xfer - x0); end
  endtask

  task automatic test_glitch;
    int nb, nv, nf;
    nb = 0; nv = 0; nf = 0;
    rx16 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (i == 1) rx16 = 1'b1;
      if (busy16) nb++;
      if (valid16) nv++;
      if (fe16 || ov16) nf++;
    end
    tests_run++;
    if (nb !== 8) begin tests_failed++; $display("FAIL glitch_busy: got %0d want 8", nb); end
    tests_run++;
    if (nv !== 0 || nf !== 0) begin tests_failed++; $display("FAIL glitch_out: got valid %0d err %0d want 0 0", nv, nf); end
    tests_run++;
    if (data16 !== 8'h00) begin tests_failed++; $display("FAIL glitch_data: got %h want 00", data16); end
  endtask

  task automatic test_frame_err;
    int x0, f0, p0;
    x0 = n_xfer; f0 = n_fe; p0 = n_pe;
    send_frame(8'h3C, even_par(8'h3C), 1'b0, NB);
    rx_i = 1'b0;
    tick(40);
    tests_run++;
    if (n_fe - f0 !== 1) begin tests_failed++; $display("FAIL ferr_pulse: got %0d want 1", n_fe - f0); end
    tests_run++;
    if (n_xfer - x0 !== 0 || valid_o !== 1'b0) begin
      tests_failed++; $display("FAIL ferr_novalid: got %0d/%b want 0/0", n_xfer - x0, valid_o);
    end
    tests_run++;
    if (busy_o !== 1'b1) begin tests_failed++; $display("FAIL ferr_busy_low: got %b want 1", busy_o); end
    tests_run++;
    if (n_pe - p0 !== 0) begin tests_failed++; $display("FAIL ferr_noparity: got %0d want 0", n_pe - p0); end
    rx_i = 1'b1;
    tick(4);
    tests_run++;
    if (busy_o !== 1'b0) begin tests_failed++; $display("FAIL ferr_busy_high: got %b want 0", busy_o); end
    tick(4);
  endtask

  task automatic test_overrun;
    int x0, o0;
    x0 = n_xfer; o0 = n_ov;
    ready_i = 1'b0;
    send_frame(8'h11, even_par(8'h11), 1'b1, NB);
    tick(2);
    tests_run++;
    if (rx_data_o !== 8'h11 || valid_o !== 1'b1) begin
      tests_failed++; $display("FAIL ovr_first: got %h/%b want 11/1", rx_data_o, valid_o);
    end
    tick(4 * CPB - 2);
    send_frame(8'h22, even_par(8'h22), 1'b1, NB);
    tick(2);
    tests_run++;
    if (rx_data_o !== 8'h11 || valid_o !== 1'b1) begin
      tests_failed++; $display("FAIL ovr_hold: got %h/%b want 11/1", rx_data_o, valid_o);
    end
    tests_run++;
    if (n_ov - o0 !== 1) begin tests_failed++; $display("FAIL ovr_pulse: got %0d want 1", n_ov - o0); end
    ready_i = 1'b1;
    tick(1);
    tests_run++;
    if (valid_o !== 1'b0) begin tests_failed++; $display("FAIL ovr_drop: got %b want 0", valid_o); end
    tick(10);
    tests_run++;
    if (n_xfer - x0 !== 1) begin tests_failed++; $display("FAIL ovr_count: got %0d want 1", n_xfer - x0); end
    tests_run++;
    if (xq.size() <= x0 || xq[x0] !== 8'h11) begin tests_failed++; $display("FAIL ovr_xdata: want 11"); end
  endtask

  task automatic test_back_to_back;
    int x0, f0, o0;
    x0 = n_xfer; f0 = n_fe; o0 = n_ov;
    ready_i = 1'b1;
    send_frame(8'hC3, even_par(8'hC3), 1'b1, NB);
    send_frame(8'h3C, even_par(8'h3C), 1'b1, NB);
    tick(3);
    tests_run++;
    if (n_xfer - x0 !== 2) begin tests_failed++; $display("FAIL b2b_count: got %0d want 2", n_xfer - x0); end
    tests_run++;
    if (xq.size() < x0 + 2 || xq[x0] !== 8'hC3 || xq[x0+1] !== 8'h3C) begin
      tests_failed++; $display("FAIL b2b_data: want c3 then 3c");
    end
    tests_run++;
    if (n_fe - f0 !== 0 || n_ov - o0 !== 0) begin
      tests_failed++; $display("FAIL b2b_errs: got %0d %0d want 0 0", n_fe - f0, n_ov - o0);
    end
  endtask

  task automatic test_reset_mid;
    int x0, f0, o0;
    x0 = n_xfer; f0 = n_fe; o0 = n_ov;
    send_frame(8'h5A, even_par(8'h5A), 1'b1, 5);
    rx_i = 1'b1;
    tick(2);
    tests_run++;
    if (busy_o !== 1'b1) begin tests_failed++; $display("FAIL rmid_busy: got %b want 1", busy_o); end
    reset_i = 1'b1;
    tick(1);
    tests_run++;
    if ({valid_o, busy_o} !== 2'b00 || rx_data_o !== 8'h00) begin
      tests_failed++; $display("FAIL rmid_rst: got %b/%h want 00/00", {valid_o, busy_o}, rx_data_o);
    end
    tick(1);
    reset_i = 1'b0;
    tick(4);
    send_frame(8'h81, even_par(8'h81), 1'b1, NB);
    tick(3);
    tests_run++;
    if (n_xfer - x0 !== 1 || xq.size() <= x0 || xq[x0] !== 8'h81) begin
      tests_failed++; $display("FAIL rmid_next: got %0d xfers want 1 of 81", n_xfer - x0);
    end
    tests_run++;
    if (n_fe - f0 !== 0 || n_ov - o0 !== 0) begin
      tests_failed++; $display("FAIL rmid_errs: got %0d %0d want 0 0", n_fe - f0, n_ov - o0);
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    int x0, p0;
    x0 = n_xfer; p0 = n_pe;
    ready_i = 1'b1;
    send_frame(8'h07, 1'b0, 1'b1, NB);
    tick(3);
    tests_run++;
    if (n_pe - p0 !== 1) begin tests_failed++; $display("FAIL par_pulse: got %0d want 1", n_pe - p0); end
    tests_run++;
    if (n_xfer - x0 !== 0) begin tests_failed++; $display("FAIL par_drop: got %0d want 0", n_xfer - x0); end
    tick(4);
    send_frame(8'h07, 1'b1, 1'b1, NB);
    tick(3);
    tests_run++;
    if (n_xfer - x0 !== 1 || xq.size() <= x0 || xq[x0] !== 8'h07) begin
      tests_failed++; $display("FAIL par_good: got %0d xfers want 1 of 07", n_xfer - x0);
    end
    tests_run++;
    if (n_pe - p0 !== 1) begin tests_failed++; $display("FAIL par_nopulse: got %0d want 1", n_pe - p0); end
  endtask
`endif

  initial begin
    tick(1);
    test_reset;
    test_basic;
    test_glitch;
    test_frame_err;
    test_overrun;
    test_back_to_back;
    test_reset_mid;
`ifdef UART_RX_PARITY_EN
    test_parity;
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
